// File: rtl/xadac_pkg.sv
// Shared vector-unit types and sizes for the xadac register file slice.
// Optional forwarding is enabled with XADAC_VRF_CTRL_FWD_EN.
package xadac_pkg;

   localparam int NoVs     = 2;
   localparam int NoVec    = 16;
   localparam int VecAddrW = 4;
   localparam int VecDataW = 32;
   localparam int NoWbDef  = 2;
   localparam int PendW    = $clog2(NoVec + 1);

   typedef logic [VecAddrW-1:0] VecAddrT;
   typedef logic [VecDataW-1:0] VecDataT;
   typedef logic [$clog2(NoWbDef)-1:0] WbIdxT;
   typedef logic [PendW-1:0] PendCntT;

   function automatic PendCntT popcnt(input logic [NoVec-1:0] v);
      PendCntT c;
      c = '0;
      for (int i = 0; i < NoVec; i++)
         c = c + PendCntT'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/xadac_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts at the rr pointer.
// Pointer advances past the winner on every grant.
module xadac_rr_arb #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] ptr;
   logic [IW-1:0] nxt;
   logic          any;

   always_comb begin
      gnt = '0;
      nxt = ptr;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[(int'(ptr) + i) % N]) begin
            any = 1'b1;
            gnt[(int'(ptr) + i) % N] = 1'b1;
            nxt = IW'(((int'(ptr) + i) % N + 1) % N);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (any)
         ptr <= nxt;
   end

endmodule

// File: rtl/xadac_vrf_ctrl.sv
// Vector register file controller: busy scoreboard, read ports, arbitrated write port.
// Define XADAC_VRF_CTRL_FWD_EN to forward the in-flight write to issue.
module xadac_vrf_ctrl
   import xadac_pkg::*;
#(
   parameter int NoWb = NoWbDef
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     iss_valid,
   output logic                     iss_ready,
   input  logic [NoVs*VecAddrW-1:0] iss_vs,
   input  logic [NoVs-1:0]          iss_vs_en,
   input  logic [VecAddrW-1:0]      iss_vd,
   input  logic                     iss_vd_en,
   output logic [NoVs*VecDataW-1:0] iss_rdata,
   input  logic [NoWb-1:0]          wb_valid,
   output logic [NoWb-1:0]          wb_ready,
   input  logic [NoWb*VecAddrW-1:0] wb_addr,
   input  logic [NoWb*VecDataW-1:0] wb_data,
   output logic [NoVs*VecAddrW-1:0] phy_raddr,
   input  logic [NoVs*VecDataW-1:0] phy_rdata,
   output logic [VecAddrW-1:0]      phy_waddr,
   output logic [VecDataW-1:0]      phy_wdata,
   output logic                     phy_we,
   output logic [PendW-1:0]         pend_cnt,
   output logic                     idle,
   output logic                     err
);

   logic [NoVec-1:0] busy;
   logic [NoVec-1:0] busy_eff;
   logic [NoVec-1:0] wclr;
   logic [NoVec-1:0] vset;
   logic             haz;
   logic [NoWb-1:0]  gnt;
   logic             gv;
   VecAddrT          ga;
   VecDataT          gd;

   xadac_rr_arb #(.N(NoWb)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (wb_valid),
      .gnt (gnt)
   );

   assign wb_ready  = gnt;
   assign gv        = |gnt;
   assign phy_raddr = iss_vs;

   assign wclr = phy_we ? (NoVec'(1) << phy_waddr) : '0;

`ifdef XADAC_VRF_CTRL_FWD_EN
   assign busy_eff = busy & ~wclr;
`else
   assign busy_eff = busy;
`endif

   always_comb begin
      haz = iss_vd_en & busy_eff[iss_vd];
      for (int i = 0; i < NoVs; i++)
         haz = haz | (iss_vs_en[i] & busy_eff[iss_vs[i*VecAddrW +: VecAddrW]]);
   end

   assign iss_ready = ~haz;
   assign vset = (iss_valid & iss_ready & iss_vd_en) ?
                 (NoVec'(1) << iss_vd) : '0;

   always_comb begin
      iss_rdata = phy_rdata;
`ifdef XADAC_VRF_CTRL_FWD_EN
      for (int i = 0; i < NoVs; i++)
         if (phy_we && phy_waddr == iss_vs[i*VecAddrW +: VecAddrW])
            iss_rdata[i*VecDataW +: VecDataW] = phy_wdata;
`endif
   end

   // grant is one-hot, so OR-selecting the winner's payload is exact
   always_comb begin
      ga = '0;
      gd = '0;
      for (int i = 0; i < NoWb; i++) begin
         ga = ga | (wb_addr[i*VecAddrW +: VecAddrW] & {VecAddrW{gnt[i]}});
         gd = gd | (wb_data[i*VecDataW +: VecDataW] & {VecDataW{gnt[i]}});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= '0;
         phy_we    <= 1'b0;
         phy_waddr <= '0;
         phy_wdata <= '0;
         err       <= 1'b0;
      end else begin
         busy   <= (busy & ~wclr) | vset;
         phy_we <= gv;
         if (gv) begin
            phy_waddr <= ga;
            phy_wdata <= gd;
         end
         if (gv && !busy[ga] && !vset[ga])
            err <= 1'b1;
      end
   end

   assign pend_cnt = popcnt(busy);
   assign idle     = (pend_cnt == '0) && !phy_we;

endmodule
